// File: rtl/pes_dpram_pkg.sv
// pes_dpram_pkg: shared types and helpers for the pes_dpram_param RAM.
//   state_t         clear-sweep FSM states (CLEAR, RUN)
//   RDW_*           same-port read-during-write mode selectors
//   byte_merge()    lane-wise merge of new data into an old word
//   lane_parity()   per-byte even-parity bits (parity build, PES_DPRAM_PARITY_EN)
// Helpers work on a fixed maximum width; callers widen and narrow at the boundary.
package pes_dpram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  localparam int RDW_READ_FIRST  = 0;
  localparam int RDW_WRITE_FIRST = 1;

  localparam int MAX_DATA_W = 512;
  localparam int MAX_LANES  = MAX_DATA_W / 8;

  typedef logic [MAX_DATA_W-1:0] word_t;
  typedef logic [MAX_LANES-1:0]  lanes_t;

  function automatic word_t byte_merge(input word_t old_word, input word_t new_word,
                                       input lanes_t be);
    word_t r;
    r = old_word;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      if (be[i]) r[i*8 +: 8] = new_word[i*8 +: 8];
    end
    return r;
  endfunction

  function automatic lanes_t lane_parity(input word_t data);
    lanes_t p;
    p = '0;
    for (int unsigned i = 0; i < MAX_LANES; i++) begin
      p[i] = ^data[i*8 +: 8];
    end
    return p;
  endfunction

endpackage

// File: rtl/pes_dpram_port_pipe.sv
// pes_dpram_port_pipe: per-port read-latency pipeline.
//   clk, rst  clock, synchronous active-high reset
//   acc       access accepted this cycle
//   pay_in    read payload for the accepted access (data, plus parity flags when enabled)
//   vld       payload-valid pulse, RD_LAT cycles after acc
//   pay_out   registered payload; holds its value while vld is low
module pes_dpram_port_pipe #(
  parameter int PAY_W  = 8,
  parameter int RD_LAT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             acc,
  input  logic [PAY_W-1:0] pay_in,
  output logic             vld,
  output logic [PAY_W-1:0] pay_out
);

  logic             v1;
  logic [PAY_W-1:0] d1;

  always_ff @(posedge clk) begin
    if (rst) begin
      v1 <= 1'b0;
      d1 <= '0;
    end else begin
      v1 <= acc;
      if (acc) d1 <= pay_in;
    end
  end

  if (RD_LAT == 2) begin : g_lat2
    always_ff @(posedge clk) begin
      if (rst) begin
        vld     <= 1'b0;
        pay_out <= '0;
      end else begin
        vld <= v1;
        if (v1) pay_out <= d1;
      end
    end
  end else begin : g_lat1
    assign vld     = v1;
    assign pay_out = d1;
  end

endmodule

// File: rtl/pes_dpram_param.sv
// pes_dpram_param: parametrised true dual-port RAM, single clock.
//   clk, rst                 clock, synchronous active-high reset
//   en_x, we_x, be_x         port access request, write, byte-lane enables (x = a, b)
//   addr_x, data_x           port address and write data
//   q_x, vld_x               read data and its valid pulse (RD_LAT cycles after request)
//   busy                     post-reset clear sweep running; accesses are dropped
//   collision                same-address conflict pulse, one cycle after the request
// Optional PES_DPRAM_PARITY_EN adds per-lane parity storage, perr_a/perr_b outputs
// aligned with vld_x, and the err_inj parity-corruption input.
module pes_dpram_param
  import pes_dpram_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int ADDR_W     = 6,
  parameter int DEPTH      = 2**ADDR_W,
  parameter int RD_LAT     = 1,
  parameter int RDW_MODE   = 0,
  parameter int CLR_ON_RST = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en_a,
  input  logic                we_a,
  input  logic [DATA_W/8-1:0] be_a,
  input  logic [ADDR_W-1:0]   addr_a,
  input  logic [DATA_W-1:0]   data_a,
  output logic [DATA_W-1:0]   q_a,
  output logic                vld_a,
  input  logic                en_b,
  input  logic                we_b,
  input  logic [DATA_W/8-1:0] be_b,
  input  logic [ADDR_W-1:0]   addr_b,
  input  logic [DATA_W-1:0]   data_b,
  output logic [DATA_W-1:0]   q_b,
  output logic                vld_b,
  output logic                busy,
  output logic                collision
`ifdef PES_DPRAM_PARITY_EN
  ,
  output logic [DATA_W/8-1:0] perr_a,
  output logic [DATA_W/8-1:0] perr_b,
  input  logic                err_inj
`endif
);

  localparam int LANES       = DATA_W / 8;
  localparam bit WRITE_FIRST = (RDW_MODE == RDW_WRITE_FIRST);

  function automatic word_t widen_word(input logic [DATA_W-1:0] d);
    word_t w;
    w = '0;
    w[DATA_W-1:0] = d;
    return w;
  endfunction

  function automatic lanes_t widen_lanes(input logic [LANES-1:0] b);
    lanes_t l;
    l = '0;
    l[LANES-1:0] = b;
    return l;
  endfunction

  logic [DATA_W-1:0] mem [DEPTH];
  state_t            state;
  logic [ADDR_W-1:0] clr_ptr;

  logic              acc_a, acc_b, rng_a, rng_b, wr_a, wr_b, same_addr, coll_d;
  logic [DATA_W-1:0] old_a, old_b, word_a, word_b, rd_a, rd_b;

  assign busy = (state == CLEAR);

  // Effective writes exclude be=0 and out-of-range addresses; those behave as reads,
  // so they neither modify storage nor count as the writing side of a collision.
  always_comb begin
    word_t m_w;
    acc_a     = en_a && (state == RUN) && !rst;
    acc_b     = en_b && (state == RUN) && !rst;
    rng_a     = (int'(addr_a) < DEPTH);
    rng_b     = (int'(addr_b) < DEPTH);
    old_a     = rng_a ? mem[addr_a] : '0;
    old_b     = rng_b ? mem[addr_b] : '0;
    wr_a      = acc_a && we_a && (|be_a) && rng_a;
    wr_b      = acc_b && we_b && (|be_b) && rng_b;
    same_addr = (addr_a == addr_b);
    coll_d    = acc_a && acc_b && same_addr && (wr_a || wr_b);

    m_w    = byte_merge(widen_word(old_b), widen_word(data_b), widen_lanes(be_b));
    word_b = m_w[DATA_W-1:0];
    // Same-address double write: B's lanes land first, A overlays its own lanes.
    m_w    = byte_merge(widen_word((wr_b && same_addr) ? word_b : old_a),
                        widen_word(data_a), widen_lanes(be_a));
    word_a = m_w[DATA_W-1:0];

    // A port that only reads always sees pre-write contents; a writing port in
    // write-first mode sees the final stored word.
    rd_a = (WRITE_FIRST && wr_a) ? word_a : old_a;
    rd_b = (WRITE_FIRST && wr_b) ? ((wr_a && same_addr) ? word_a : word_b) : old_b;
  end

`ifdef PES_DPRAM_PARITY_EN
  localparam int PAY_W = DATA_W + LANES;

  logic [LANES-1:0] par [DEPTH];
  logic [LANES-1:0] old_par_a, old_par_b, npar_a, npar_b, rdpar_a, rdpar_b;
  logic [LANES-1:0] perr_d_a, perr_d_b;

  always_comb begin
    lanes_t calc_a, calc_b, chk_a, chk_b;
    calc_a    = lane_parity(widen_word(word_a));
    calc_b    = lane_parity(widen_word(word_b));
    old_par_a = rng_a ? par[addr_a] : '0;
    old_par_b = rng_b ? par[addr_b] : '0;
    npar_a    = old_par_a;
    npar_b    = old_par_b;
    for (int unsigned i = 0; i < LANES; i++) begin
      if (wr_b && same_addr && be_b[i]) npar_a[i] = calc_b[i] ^ err_inj;
      if (be_a[i]) npar_a[i] = calc_a[i] ^ err_inj;
      if (be_b[i]) npar_b[i] = calc_b[i] ^ err_inj;
    end
    rdpar_a  = (WRITE_FIRST && wr_a) ? npar_a : old_par_a;
    rdpar_b  = (WRITE_FIRST && wr_b) ? ((wr_a && same_addr) ? npar_a : npar_b) : old_par_b;
    chk_a    = lane_parity(widen_word(rd_a));
    chk_b    = lane_parity(widen_word(rd_b));
    perr_d_a = chk_a[LANES-1:0] ^ rdpar_a;
    perr_d_b = chk_b[LANES-1:0] ^ rdpar_b;
  end

  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      par[clr_ptr] <= '0;
    end else begin
      if (wr_a) par[addr_a] <= npar_a;
      if (wr_b && !(wr_a && same_addr)) par[addr_b] <= npar_b;
    end
  end
`else
  localparam int PAY_W = DATA_W;
`endif

  logic [PAY_W-1:0] pay_in_a, pay_in_b, pay_out_a, pay_out_b;

`ifdef PES_DPRAM_PARITY_EN
  assign pay_in_a = {perr_d_a, rd_a};
  assign pay_in_b = {perr_d_b, rd_b};
  assign perr_a   = pay_out_a[PAY_W-1:DATA_W];
  assign perr_b   = pay_out_b[PAY_W-1:DATA_W];
`else
  assign pay_in_a = rd_a;
  assign pay_in_b = rd_b;
`endif

  assign q_a = pay_out_a[DATA_W-1:0];
  assign q_b = pay_out_b[DATA_W-1:0];

  // Storage: clear sweep has exclusive use; a same-address double write is stored once.
  always_ff @(posedge clk) begin
    if (state == CLEAR) begin
      mem[clr_ptr] <= '0;
    end else begin
      if (wr_a) mem[addr_a] <= word_a;
      if (wr_b && !(wr_a && same_addr)) mem[addr_b] <= word_b;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLR_ON_RST != 0) ? CLEAR : RUN;
      clr_ptr   <= '0;
      collision <= 1'b0;
    end else begin
      collision <= coll_d;
      if (state == CLEAR) begin
        clr_ptr <= clr_ptr + ADDR_W'(1);
        if (clr_ptr == ADDR_W'(DEPTH - 1)) state <= RUN;
      end
    end
  end

  pes_dpram_port_pipe #(.PAY_W(PAY_W), .RD_LAT(RD_LAT)) u_pipe_a (
    .clk     (clk),
    .rst     (rst),
    .acc     (acc_a),
    .pay_in  (pay_in_a),
    .vld     (vld_a),
    .pay_out (pay_out_a)
  );

  pes_dpram_port_pipe #(.PAY_W(PAY_W), .RD_LAT(RD_LAT)) u_pipe_b (
    .clk     (clk),
    .rst     (rst),
    .acc     (acc_b),
    .pay_in  (pay_in_b),
    .vld     (vld_b),
    .pay_out (pay_out_b)
  );

endmodule

// File: tb/tb_pes_dpram_param.sv
// tb_pes_dpram_param: two DUT configurations driven side by side.
//   k=0: DATA_W=8,  DEPTH=64, RD_LAT=1, read-first
//   k=1: DATA_W=16, DEPTH=48, RD_LAT=2, write-first
// A word-level reference model predicts every output on every cycle.
module tb_pes_dpram_param;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        en_a [2], we_a [2], en_b [2], we_b [2];
  logic [1:0]  be_a [2], be_b [2];
  logic [5:0]  addr_a [2], addr_b [2];
  logic [15:0] data_a [2], data_b [2];

  logic [7:0]  q_a0, q_b0;
  logic [15:0] q_a1, q_b1;
  logic        vld_a0, vld_b0, vld_a1, vld_b1, busy0, busy1, coll0, coll1;
`ifdef PES_DPRAM_PARITY_EN
  logic        err_inj;
  logic [0:0]  perr_a0, perr_b0;
  logic [1:0]  perr_a1, perr_b1;
`endif

  pes_dpram_param #(.DATA_W(8), .ADDR_W(6), .DEPTH(64), .RD_LAT(1), .RDW_MODE(0),
                    .CLR_ON_RST(1)) u_dut0 (
    .clk(clk), .rst(rst),
    .en_a(en_a[0]), .we_a(we_a[0]), .be_a(be_a[0][0:0]), .addr_a(addr_a[0]),
    .data_a(data_a[0][7:0]), .q_a(q_a0), .vld_a(vld_a0),
    .en_b(en_b[0]), .we_b(we_b[0]), .be_b(be_b[0][0:0]), .addr_b(addr_b[0]),
    .data_b(data_b[0][7:0]), .q_b(q_b0), .vld_b(vld_b0),
    .busy(busy0), .collision(coll0)
`ifdef PES_DPRAM_PARITY_EN
    , .perr_a(perr_a0), .perr_b(perr_b0), .err_inj(err_inj)
`endif
  );

  pes_dpram_param #(.DATA_W(16), .ADDR_W(6), .DEPTH(48), .RD_LAT(2), .RDW_MODE(1),
                    .CLR_ON_RST(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .en_a(en_a[1]), .we_a(we_a[1]), .be_a(be_a[1]), .addr_a(addr_a[1]),
    .data_a(data_a[1]), .q_a(q_a1), .vld_a(vld_a1),
    .en_b(en_b[1]), .we_b(we_b[1]), .be_b(be_b[1]), .addr_b(addr_b[1]),
    .data_b(data_b[1]), .q_b(q_b1), .vld_b(vld_b1),
    .busy(busy1), .collision(coll1)
`ifdef PES_DPRAM_PARITY_EN
    , .perr_a(perr_a1), .perr_b(perr_b1), .err_inj(err_inj)
`endif
  );

  // ---------------- reference model ----------------
  typedef struct {
    int          k;
    int          port;
    int          due;
    logic [15:0] d;
  } exp_t;

  exp_t        pend [$];
  logic [15:0] mm [2][64];
  int          busy_cnt [2];
  logic [15:0] hold [2][2];
  bit          coll_exp [2];
  int          cyc;
  int          n_chk, n_fail;

  function automatic int depth_of(int k);   return (k == 0) ? 64 : 48; endfunction
  function automatic int lat_of(int k);     return (k == 0) ? 1 : 2;   endfunction
  function automatic bit wfirst_of(int k);  return (k == 1);           endfunction
  function automatic logic [1:0] lanes_of(int k); return (k == 0) ? 2'b01 : 2'b11; endfunction

  function automatic logic [15:0] lane_merge(logic [15:0] old_w, logic [15:0] new_w,
                                             logic [1:0] be);
    logic [15:0] m;
    m = {{8{be[1]}}, {8{be[0]}}};
    return (old_w & ~m) | (new_w & m);
  endfunction

  function automatic logic [15:0] obs_q(int k, int p);
    if (k == 0) return (p == 0) ? {8'h00, q_a0} : {8'h00, q_b0};
    return (p == 0) ? q_a1 : q_b1;
  endfunction

  function automatic logic obs_v(int k, int p);
    if (k == 0) return (p == 0) ? vld_a0 : vld_b0;
    return (p == 0) ? vld_a1 : vld_b1;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_access(input int k);
    logic [1:0]  bea, beb;
    logic [15:0] old_a, old_b;
    bit          ra, rb, wa, wb;
    ra    = int'(addr_a[k]) < depth_of(k);
    rb    = int'(addr_b[k]) < depth_of(k);
    bea   = be_a[k] & lanes_of(k);
    beb   = be_b[k] & lanes_of(k);
    wa    = en_a[k] && we_a[k] && (bea != 2'b00) && ra;
    wb    = en_b[k] && we_b[k] && (beb != 2'b00) && rb;
    old_a = ra ? mm[k][addr_a[k]] : 16'h0000;
    old_b = rb ? mm[k][addr_b[k]] : 16'h0000;
    coll_exp[k] = en_a[k] && en_b[k] && (addr_a[k] == addr_b[k]) && (wa || wb);
    // B first so that A owns every lane it enables on a shared address.
    if (wb) mm[k][addr_b[k]] = lane_merge(mm[k][addr_b[k]], data_b[k], beb);
    if (wa) mm[k][addr_a[k]] = lane_merge(mm[k][addr_a[k]], data_a[k], bea);
    if (en_a[k])
      pend.push_back('{k, 0, cyc + lat_of(k), (wfirst_of(k) && wa) ? mm[k][addr_a[k]] : old_a});
    if (en_b[k])
      pend.push_back('{k, 1, cyc + lat_of(k), (wfirst_of(k) && wb) ? mm[k][addr_b[k]] : old_b});
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        for (int i = 0; i < 64; i++) mm[k][i] = 16'h0000;
        busy_cnt[k] = depth_of(k);
        hold[k][0]  = 16'h0000;
        hold[k][1]  = 16'h0000;
        coll_exp[k] = 1'b0;
        for (int i = pend.size() - 1; i >= 0; i--)
          if (pend[i].k == k) pend.delete(i);
      end else if (busy_cnt[k] > 0) begin
        busy_cnt[k]--;
        coll_exp[k] = 1'b0;
      end else begin
        model_access(k);
      end
    end
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 2; k++) begin
      for (int p = 0; p < 2; p++) begin
        logic        ev;
        logic [15:0] eq;
        ev = 1'b0;
        eq = hold[k][p];
        for (int i = pend.size() - 1; i >= 0; i--) begin
          if (pend[i].k == k && pend[i].port == p && pend[i].due == cyc) begin
            ev = 1'b1;
            eq = pend[i].d;
            pend.delete(i);
          end
        end
        hold[k][p] = eq;
        check_eq($sformatf("vld_%s%0d", (p == 0) ? "a" : "b", k), 32'(obs_v(k, p)), 32'(ev));
        check_eq($sformatf("q_%s%0d", (p == 0) ? "a" : "b", k), 32'(obs_q(k, p)), 32'(eq));
      end
    end
    check_eq("busy0", 32'(busy0), 32'(busy_cnt[0] > 0));
    check_eq("busy1", 32'(busy1), 32'(busy_cnt[1] > 0));
    check_eq("collision0", 32'(coll0), 32'(coll_exp[0]));
    check_eq("collision1", 32'(coll1), 32'(coll_exp[1]));
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  task automatic idle();
    for (int k = 0; k < 2; k++) begin
      en_a[k] = 1'b0; we_a[k] = 1'b0; be_a[k] = 2'b00; addr_a[k] = '0; data_a[k] = '0;
      en_b[k] = 1'b0; we_b[k] = 1'b0; be_b[k] = 2'b00; addr_b[k] = '0; data_b[k] = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int          n;
    logic        v_seen [6];
    logic [15:0] q_seen [6];
    n_chk = 0; n_fail = 0; cyc = 0;
`ifdef PES_DPRAM_PARITY_EN
    err_inj = 1'b0;
`endif
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;

    // Clear sweep length after reset.
    n = 0;
    while (busy0 === 1'b1 && n < 200) begin tick(); n++; end
    check_eq("sweep_len", 32'(n), 32'd64);

    // Read of the top address after the sweep.
    idle(); en_a[0] = 1'b1; addr_a[0] = 6'h3F;
    tick();
    check_eq("rd3f_vld", 32'(vld_a0), 32'd1);
    check_eq("rd3f_q", 32'(q_a0), 32'h00);

    // Independent writes on both ports, then crossed reads.
    idle();
    en_a[0] = 1'b1; we_a[0] = 1'b1; be_a[0] = 2'b01; addr_a[0] = 6'h01; data_a[0] = 16'h0033;
    en_b[0] = 1'b1; we_b[0] = 1'b1; be_b[0] = 2'b01; addr_b[0] = 6'h02; data_b[0] = 16'h0044;
    tick();
    idle();
    en_a[0] = 1'b1; addr_a[0] = 6'h02;
    en_b[0] = 1'b1; addr_b[0] = 6'h01;
    tick();
    check_eq("xrd_q_a", 32'(q_a0), 32'h44);
    check_eq("xrd_q_b", 32'(q_b0), 32'h33);
    check_eq("xrd_coll", 32'(coll0), 32'd0);

    // Double write to one address on the 16-bit instance: A's lanes win.
    idle();
    en_a[1] = 1'b1; we_a[1] = 1'b1; be_a[1] = 2'b01; addr_a[1] = 6'h05; data_a[1] = 16'hAAAA;
    en_b[1] = 1'b1; we_b[1] = 1'b1; be_b[1] = 2'b11; addr_b[1] = 6'h05; data_b[1] = 16'hBBBB;
    tick();
    check_eq("dw_coll", 32'(coll1), 32'd1);
    idle(); tick();
    en_a[1] = 1'b1; addr_a[1] = 6'h05;
    tick();
    idle(); tick();
    check_eq("dw_readback", 32'(q_a1), 32'hBBAA);

    // Write on A while B reads the same word, both read-during-write modes.
    idle();
    en_a[0] = 1'b1; we_a[0] = 1'b1; be_a[0] = 2'b01; addr_a[0] = 6'h07; data_a[0] = 16'h0011;
    en_a[1] = 1'b1; we_a[1] = 1'b1; be_a[1] = 2'b11; addr_a[1] = 6'h07; data_a[1] = 16'h0011;
    tick();
    data_a[0] = 16'h0022; data_a[1] = 16'h0022;
    en_b[0] = 1'b1; addr_b[0] = 6'h07;
    en_b[1] = 1'b1; addr_b[1] = 6'h07;
    tick();
    check_eq("rw_coll0", 32'(coll0), 32'd1);
    check_eq("rw_coll1", 32'(coll1), 32'd1);
    check_eq("rw_q_a0_rf", 32'(q_a0), 32'h11);
    check_eq("rw_q_b0", 32'(q_b0), 32'h11);
    idle(); tick();
    check_eq("rw_q_a1_wf", 32'(q_a1), 32'h0022);
    check_eq("rw_q_b1", 32'(q_b1), 32'h0011);

    // Back-to-back reads through the two-stage pipeline.
    for (int i = 1; i <= 3; i++) begin
      idle();
      en_a[1] = 1'b1; we_a[1] = 1'b1; be_a[1] = 2'b11; addr_a[1] = 6'(i);
      data_a[1] = 16'(i * 16'h1111);
      tick();
    end
    idle(); tick(); tick();
    for (int i = 0; i < 6; i++) begin
      idle();
      if (i < 3) begin en_a[1] = 1'b1; addr_a[1] = 6'(i + 1); end
      tick();
      v_seen[i] = vld_a1;
      q_seen[i] = q_a1;
    end
    check_eq("lat2_vld_first", 32'(v_seen[0]), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      check_eq($sformatf("lat2_vld%0d", i), 32'(v_seen[i]), 32'd1);
      check_eq($sformatf("lat2_q%0d", i), 32'(q_seen[i]), 32'(i * 16'h1111));
    end
    check_eq("lat2_vld_after", 32'(v_seen[4]), 32'd0);

`ifdef PES_DPRAM_PARITY_EN
    idle(); err_inj = 1'b1;
    en_a[0] = 1'b1; we_a[0] = 1'b1; be_a[0] = 2'b01; addr_a[0] = 6'h09; data_a[0] = 16'h005A;
    tick();
    idle(); err_inj = 1'b0; en_a[0] = 1'b1; addr_a[0] = 6'h09;
    tick();
    check_eq("perr_injected", 32'(perr_a0), 32'd1);
    idle();
    en_a[0] = 1'b1; we_a[0] = 1'b1; be_a[0] = 2'b01; addr_a[0] = 6'h09; data_a[0] = 16'h005A;
    tick();
    idle(); en_a[0] = 1'b1; addr_a[0] = 6'h09;
    tick();
    check_eq("perr_clean", 32'(perr_a0), 32'd0);
`endif

    // Randomized traffic with a reset in the middle.
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < 2; k++) begin
        en_a[k]   = ($urandom_range(0, 3) != 0);
        we_a[k]   = 1'($urandom_range(0, 1));
        be_a[k]   = 2'($urandom);
        addr_a[k] = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
        data_a[k] = 16'($urandom);
        en_b[k]   = ($urandom_range(0, 3) != 0);
        we_b[k]   = 1'($urandom_range(0, 1));
        be_b[k]   = 2'($urandom);
        addr_b[k] = ($urandom_range(0, 9) == 0) ? 6'($urandom) : 6'($urandom_range(0, 7));
        data_b[k] = 16'($urandom);
      end
      rst = (c == 700);
      tick();
    end
    rst = 1'b0;

    // Reset partway through a sweep restarts it from word 0.
    idle();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    n = 0;
    while (busy0 === 1'b1 && n < 200) begin tick(); n++; end
    check_eq("resweep_len", 32'(n), 32'd64);
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pes_dpram_param.md
Name: pes_dpram_param

Overview:
Parametrised true dual-port RAM. Successor to the fixed 8-bit/64-entry dual-port RAM.
- Adds per-port enables and byte-lane write enables.
- Adds configurable read latency and read-during-write mode.
- Defines cross-port collision behaviour and a post-reset memory-clear sweep.
- Shared-buffer storage for pipelined datapath stages; both ports on one clock.

Parameters:
DATA_W, 8, data width; multiple of 8.
ADDR_W, 6, address width.
DEPTH, 2**ADDR_W, number of words; must be <= 2**ADDR_W.
RD_LAT, 1, read latency in cycles; legal values 1 or 2.
RDW_MODE, 0, same-port read-during-write: 0 = read-first (old data), 1 = write-first (new merged data).
CLR_ON_RST, 1, 1 = zero all words after reset.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
en_a  in  1  port A access request
we_a  in  1  port A write (valid with en_a)
be_a  in  DATA_W/8  port A byte-lane enables
addr_a  in  ADDR_W  port A address
data_a  in  DATA_W  port A write data
q_a  out  DATA_W  port A read data
vld_a  out  1  q_a valid pulse
en_b, we_b, be_b, addr_b, data_b, q_b, vld_b: same as port A, for port B
busy  out  1  clear sweep in progress; accesses dropped
collision  out  1  same-address conflict pulse

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous, active-high.
- Reset values: q_a=q_b=0, vld_a=vld_b=0, collision=0, clr_ptr=0. busy=1 if CLR_ON_RST, else 0.
- FSM states: CLEAR, RUN.
  - rst -> CLEAR if CLR_ON_RST, else RUN.
  - CLEAR writes 0 to word clr_ptr each cycle; clr_ptr increments.
  - After writing DEPTH-1, go to RUN. busy deasserts the following cycle.
  - Full sweep = DEPTH cycles.
  - rst asserted mid-sweep restarts the sweep at word 0.
- In CLEAR: en_a/en_b are ignored. No writes, no vld, no collision.
- Accepted access: en_x=1 while in RUN. Each accepted access produces one vld_x pulse exactly RD_LAT cycles later.
- Read data:
  - en_x=1, we_x=0: q_x = word contents.
  - en_x=1, we_x=1: q_x = old word (RDW_MODE=0) or new merged word (RDW_MODE=1).
- When vld_x=0, q_x holds its last value.
- Writes update only byte lanes with be_x[i]=1. be_x=0 with we_x=1 acts as a read.
- Addresses >= DEPTH: writes dropped, read returns 0, vld still pulses.
- Cross-port collision: both ports accepted, addr_a==addr_b, and at least one writing.
  - Both writing: per lane, port A wins where be_a[i]=1; port B lands only in lanes where be_a[i]=0.
  - One reading, other writing: reader always receives old data, regardless of RDW_MODE.
  - collision pulses high 1 cycle after the conflicting request cycle.
  - Two reads of the same address: no collision.
- Pipeline: RD_LAT=2 adds one output register stage. Back-to-back accesses are accepted every cycle; no stalls.

Optional Feature:
PES_DPRAM_PARITY_EN
- Defined:
  - Each byte lane stores an extra even-parity bit, computed on write. The clear sweep writes parity 0.
  - Adds output ports perr_a and perr_b, width DATA_W/8, aligned with vld_x.
  - perr_x[i]=1 when stored parity mismatches recomputed parity. Reset value 0.
  - Adds input err_inj (1 bit): when high, flips the stored parity bit of every lane written in that cycle. For verification.
- Undefined: no parity storage and none of these ports.

Decomposition:
- Package pes_dpram_pkg holds:
  - state enum {CLEAR, RUN}
  - RDW_READ_FIRST=0, RDW_WRITE_FIRST=1 constants
  - function byte_merge(old, new, be)
  - function lane_parity(data) (used only when PES_DPRAM_PARITY_EN is defined)
- Sub-module pes_dpram_port_pipe: per-port RD_LAT pipeline for q/vld (and perr), instantiated twice.
- Storage array, clear FSM and collision resolution live in the top module.

Test Plan:
- Reset, default params -> busy=1 for 64 cycles then 0. Read addr 0x3F -> q_a=0x00, vld_a 1 cycle later.
- Port A writes 0x33 to addr 0x01; port B writes 0x44 to addr 0x02 in the same cycle. Next cycle A reads 0x02, B reads 0x01 -> q_a=0x44, q_b=0x33, no collision.
- DATA_W=16. Word 0x05 preloaded 0x0000. A writes 0xAAAA with be_a=01; B writes 0xBBBB with be_b=11, both to addr 0x05 -> collision=1 next cycle; readback = 0xBBAA.
- Word 0x07=0x11. A writes 0x22 to 0x07 while B reads 0x07 -> q_b=0x11, collision pulses. RDW_MODE=1: A's own q_a=0x22; RDW_MODE=0: q_a=0x11.
- RD_LAT=2, continuous reads on port A of addrs 1,2,3 -> vld_a high for 3 consecutive cycles starting 2 cycles after the first request, data in order. rst asserted at sweep cycle 10 -> sweep restarts; busy=1 for a further 64 cycles.
- PES_DPRAM_PARITY_EN defined: write 0x5A with err_inj=1, then read the same address -> perr_a=1; rewrite 0x5A with err_inj=0 and read -> perr_a=0.
